// File: rtl/dcache_axi_ctrl.sv
// Data-cache AXI bridge: turns dcache line refills and uncached single-word
// reads/writes into AXI4 read bursts and single-beat write transactions.
module dcache_axi_ctrl #(
   parameter int LINE_WORDS = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       axi_rreq_i,
   input  logic                       uc_rreq_i,
   input  logic                       uc_wreq_i,
   input  logic [31:0]                addr_i,
   input  logic [3:0]                 wen_i,
   input  logic [31:0]                wdata_i,
   output logic                       rend_o,
   output logic                       wend_o,
   output logic [LINE_WORDS*32-1:0]   cacheline_rdata_o,
   output logic                       busy_o,
   output logic [31:0]                araddr_o,
   output logic [7:0]                 arlen_o,
   output logic                       arvalid_o,
   input  logic                       arready_i,
   input  logic [31:0]                rdata_i,
   input  logic                       rlast_i,
   input  logic                       rvalid_i,
   output logic                       rready_o,
   output logic [31:0]                awaddr_o,
   output logic                       awvalid_o,
   input  logic                       awready_i,
   output logic [31:0]                wdata_o,
   output logic [3:0]                 wstrb_o,
   output logic                       wvalid_o,
   input  logic                       wready_i,
   input  logic                       bvalid_i,
   output logic                       bready_o
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_AR,
      S_R,
      S_AW_W,
      S_B
   } state_t;

   state_t      state_reg;
   logic [2:0]  beat_reg;
   logic [31:0] addr_reg;
   logic [31:0] wdata_reg;
   logic [3:0]  wstrb_reg;
   logic [7:0]  arlen_reg;
   logic        arvalid_reg;
   logic        rready_reg;
   logic        awvalid_reg;
   logic        wvalid_reg;
   logic        bready_reg;
   logic        rend_reg;
   logic        wend_reg;

   logic        aw_done;
   logic        w_done;
   logic        beat_fire;

   // A channel counts as done once its valid has dropped or is handshaking now.
   assign aw_done   = !awvalid_reg || awready_i;
   assign w_done    = !wvalid_reg || wready_i;
   assign beat_fire = (state_reg == S_R) && rvalid_i;

   assign busy_o    = (state_reg != S_IDLE);
   assign rend_o    = rend_reg;
   assign wend_o    = wend_reg;
   assign araddr_o  = addr_reg;
   assign awaddr_o  = addr_reg;
   assign arlen_o   = arlen_reg;
   assign arvalid_o = arvalid_reg;
   assign rready_o  = rready_reg;
   assign awvalid_o = awvalid_reg;
   assign wdata_o   = wdata_reg;
   assign wstrb_o   = wstrb_reg;
   assign wvalid_o  = wvalid_reg;
   assign bready_o  = bready_reg;

   // Main FSM: arbitrates requests in IDLE and sequences the AXI channels.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg   <= S_IDLE;
         beat_reg    <= '0;
         addr_reg    <= '0;
         wdata_reg   <= '0;
         wstrb_reg   <= '0;
         arlen_reg   <= '0;
         arvalid_reg <= 1'b0;
         rready_reg  <= 1'b0;
         awvalid_reg <= 1'b0;
         wvalid_reg  <= 1'b0;
         bready_reg  <= 1'b0;
         rend_reg    <= 1'b0;
         wend_reg    <= 1'b0;
      end else begin
         rend_reg <= 1'b0;
         wend_reg <= 1'b0;
         case (state_reg)
            S_IDLE: begin
               if (uc_rreq_i) begin
                  addr_reg    <= addr_i;
                  arlen_reg   <= 8'd0;
                  arvalid_reg <= 1'b1;
                  beat_reg    <= '0;
                  state_reg   <= S_AR;
               end else if (uc_wreq_i) begin
                  addr_reg    <= addr_i;
                  wdata_reg   <= wdata_i;
                  wstrb_reg   <= wen_i;
                  awvalid_reg <= 1'b1;
                  wvalid_reg  <= 1'b1;
                  state_reg   <= S_AW_W;
               end else if (axi_rreq_i) begin
                  addr_reg    <= addr_i;
                  arlen_reg   <= 8'(LINE_WORDS - 1);
                  arvalid_reg <= 1'b1;
                  beat_reg    <= '0;
                  state_reg   <= S_AR;
               end
            end
            S_AR: begin
               if (arready_i) begin
                  arvalid_reg <= 1'b0;
                  rready_reg  <= 1'b1;
                  state_reg   <= S_R;
               end
            end
            S_R: begin
               if (rvalid_i) begin
                  beat_reg <= beat_reg + 3'd1;
                  // rlast closes the burst no matter how many beats arrived
                  if (rlast_i) begin
                     rready_reg <= 1'b0;
                     rend_reg   <= 1'b1;
                     state_reg  <= S_IDLE;
                  end
               end
            end
            S_AW_W: begin
               if (awvalid_reg && awready_i) begin
                  awvalid_reg <= 1'b0;
               end
               if (wvalid_reg && wready_i) begin
                  wvalid_reg <= 1'b0;
               end
               if (aw_done && w_done) begin
                  bready_reg <= 1'b1;
                  state_reg  <= S_B;
               end
            end
            S_B: begin
               if (bvalid_i) begin
                  bready_reg <= 1'b0;
                  wend_reg   <= 1'b1;
                  state_reg  <= S_IDLE;
               end
            end
            default: begin
               state_reg <= S_IDLE;
            end
         endcase
      end
   end

   // One register per line word; only the word selected by the beat counter loads.
   generate
      for (genvar gi = 0; gi < LINE_WORDS; gi++) begin : g_word
         logic [31:0] word_reg;

         // Capture read data for this word slot on a matching beat.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               word_reg <= '0;
            end else if (beat_fire && (beat_reg == 3'(gi))) begin
               word_reg <= rdata_i;
            end
         end

         assign cacheline_rdata_o[gi*32 +: 32] = word_reg;
      end
   endgenerate

endmodule
